// File: rtl/mpmc12_cmd_arbfifo.sv
// Port-request arbiter feeding a first-word-fall-through command FIFO for mpmc12.
// Round-robin among client ports, optional priority port bounded by a starvation limit.
module mpmc12_cmd_arbfifo #(
    parameter int NPORT      = 8,
    parameter int REQW       = 300,
    parameter int DEPTH      = 16,
    parameter int PRIO_EN    = 0,
    parameter int PRIO_PORT  = 0,
    parameter int STARVE_LIM = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NPORT-1:0]           req_valid_i,
    input  logic [NPORT*REQW-1:0]      req_i,
    output logic [NPORT-1:0]           req_ready_o,
    output logic                       out_valid_o,
    output logic [$clog2(NPORT)-1:0]   out_port_o,
    output logic [REQW-1:0]            out_req_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(NPORT);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [PW-1:0] PRIO_IDX = PW'(PRIO_PORT);

    logic [CW-1:0] count_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [PW-1:0] rr_ptr_reg;
    logic [SW-1:0] starve_cnt_reg;

    logic [PW-1:0]   port_mem [DEPTH];
    logic [REQW-1:0] req_mem  [DEPTH];

    logic [REQW-1:0] req_word [NPORT];

    logic [NPORT-1:0] rr_mask;
    logic             prio_req;
    logic             other_req;
    logic             rr_found;
    logic [PW-1:0]    rr_win;
    logic [PW:0]      scan_sum;
    logic [PW-1:0]    scan_idx;
    logic             prio_win;
    logic             grant_any;
    logic [PW-1:0]    win;
    logic             full;
    logic             push;
    logic             pop;

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_unpack
            assign req_word[gi] = req_i[gi*REQW +: REQW];
        end
    endgenerate

    // The priority port is taken out of the round-robin pool so that an
    // exhausted starvation budget always hands the slot to someone else.
    always_comb begin
        rr_mask  = req_valid_i;
        prio_req = 1'b0;
        if (PRIO_EN != 0) begin
            rr_mask[PRIO_IDX] = 1'b0;
            prio_req          = req_valid_i[PRIO_IDX];
        end
        other_req = |rr_mask;
    end

    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            scan_sum = {1'b0, rr_ptr_reg} + (PW+1)'(i);
            if (scan_sum >= (PW+1)'(NPORT)) begin
                scan_sum = scan_sum - (PW+1)'(NPORT);
            end
            scan_idx = scan_sum[PW-1:0];
            if (!rr_found && rr_mask[scan_idx]) begin
                rr_found = 1'b1;
                rr_win   = scan_idx;
            end
        end
    end

    // A lone priority requester still wins at the limit; nobody is starved then.
    assign prio_win  = (PRIO_EN != 0) && prio_req &&
                       ((starve_cnt_reg < SW'(STARVE_LIM)) || !other_req);
    assign full      = (count_reg == CW'(DEPTH));
    assign grant_any = !rst_i && !full && (prio_win || rr_found);
    assign win       = prio_win ? PRIO_IDX : rr_win;
    assign push      = grant_any;
    assign pop       = out_valid_o && out_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (grant_any) begin
            req_ready_o[win] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg      <= '0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            rr_ptr_reg     <= '0;
            starve_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push) begin
                if (prio_win) begin
                    starve_cnt_reg <= other_req ? starve_cnt_reg + 1'b1 : '0;
                end else begin
                    starve_cnt_reg <= '0;
                    rr_ptr_reg     <= (rr_win == PW'(NPORT-1)) ? '0 : rr_win + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            port_mem[wr_ptr_reg] <= win;
            req_mem[wr_ptr_reg]  <= req_word[win];
        end
    end

    assign out_valid_o = (count_reg != '0);
    assign out_port_o  = port_mem[rd_ptr_reg];
    assign out_req_o   = req_mem[rd_ptr_reg];
    assign count_o     = count_reg;
    assign full_o      = full;
    assign empty_o     = (count_reg == '0);

endmodule
